// File: rtl/pe_mac_pkg.sv
// pe_mac_pkg: opcode and accumulator-state types plus the saturating adder shared by pe_mac_pipe.
//   op_e        : opcodes with dedicated arithmetic; any other value passes operand a through
//   acc_state_e : accumulate burst state (IDLE, OPEN)
//   sat_add     : x + y clamped to the signed range of a w-bit word, computed in SAT_W bits
package pe_mac_pkg;

    typedef enum logic [7:0] {
        OP_MADD = 8'h00,
        OP_MSUB = 8'h01,
        OP_MUL  = 8'h02,
        OP_ACC  = 8'h03
    } op_e;

    typedef enum logic {IDLE, OPEN} acc_state_e;

    localparam int SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] x,
        input logic signed [SAT_W-1:0] y,
        input int                      w
    );
        logic signed [SAT_W-1:0] s, hi, lo;
        s  = x + y;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction

endpackage

// File: rtl/pe_mac_pipe_stage_pipe.sv
// pe_mac_stage_pipe: DEPTH-deep stall-able delay line for pipeline stage records.
//   aclk, aresetn : clock, synchronous active-low reset (clears every stage)
//   advance       : shift enable; low holds every stage
//   d_in / d_out  : stage record entering / leaving the line (DEPTH == 0 is a plain wire)
module pe_mac_stage_pipe #(
    parameter int  DEPTH   = 2,
    parameter type stage_t = logic
) (
    input  logic   aclk,
    input  logic   aresetn,
    input  logic   advance,
    input  stage_t d_in,
    output stage_t d_out
);

    if (DEPTH == 0) begin : g_wire
        assign d_out = d_in;
    end else begin : g_regs
        stage_t q [DEPTH];
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            end else if (advance) begin
                q[0] <= d_in;
                for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
            end
        end
        assign d_out = q[DEPTH-1];
    end

endmodule

// File: rtl/pe_mac_pipe.sv
// pe_mac_pipe: signed multiply-accumulate PE with AXI-Stream join, backpressure and tlast-delimited accumulation.
//   aclk, aresetn                  : clock, synchronous active-low reset
//   s_axis_{a,b,c,operation}_*     : joined operand/opcode streams; a carries tlast for accumulate bursts
//   s_axis_tready                  : shared ready, low during reset and while the output is stalled
//   m_axis_result_*                : result stream; tuser = number of beats folded into the result
// Build option PE_MAC_SAT_EN: saturate every op result and every accumulator step instead of wrapping.
// Pipeline: multiply register, LATENCY-2 delay stages, accumulate/output register.
module pe_mac_pipe
    import pe_mac_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_a_tvalid,
    input  logic [DATA_W-1:0] s_axis_a_tdata,
    input  logic              s_axis_a_tlast,
    input  logic              s_axis_b_tvalid,
    input  logic [DATA_W-1:0] s_axis_b_tdata,
    input  logic              s_axis_c_tvalid,
    input  logic [DATA_W-1:0] s_axis_c_tdata,
    input  logic              s_axis_operation_tvalid,
    input  logic [7:0]        s_axis_operation_tdata,
    output logic              s_axis_tready,
    output logic              m_axis_result_tvalid,
    output logic [DATA_W-1:0] m_axis_result_tdata,
    output logic [CNT_W-1:0]  m_axis_result_tuser,
    input  logic              m_axis_result_tready
);

    // The saturating build keeps the full product so clamping sees the true value.
`ifdef PE_MAC_SAT_EN
    localparam int PROD_W = 2 * DATA_W;
`else
    localparam int PROD_W = DATA_W;
`endif

    typedef struct packed {
        logic                     valid;
        op_e                      op;
        logic                     last;
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        logic signed [DATA_W-1:0] c;
        logic signed [PROD_W-1:0] product;
    } stage_t;

    stage_t                   mul_q, d;
    acc_state_e               state;
    logic signed [DATA_W-1:0] acc, acc_next, op_res;
    logic [CNT_W-1:0]         cnt, cnt_next;
    logic                     run, advance, accept;

    assign advance       = !m_axis_result_tvalid || m_axis_result_tready;
    assign s_axis_tready = run && advance;
    assign accept        = s_axis_tready && s_axis_a_tvalid && s_axis_b_tvalid &&
                           s_axis_c_tvalid && s_axis_operation_tvalid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mul_q <= '0;
        end else if (advance) begin
            mul_q <= '{valid:   accept,
                       op:      op_e'(s_axis_operation_tdata),
                       last:    s_axis_a_tlast,
                       a:       s_axis_a_tdata,
                       b:       s_axis_b_tdata,
                       c:       s_axis_c_tdata,
                       product: PROD_W'($signed(s_axis_a_tdata)) * PROD_W'($signed(s_axis_b_tdata))};
        end
    end

    pe_mac_stage_pipe #(
        .DEPTH   (LATENCY - 2),
        .stage_t (stage_t)
    ) u_stage_pipe (
        .aclk    (aclk),
        .aresetn (aresetn),
        .advance (advance),
        .d_in    (mul_q),
        .d_out   (d)
    );

`ifdef PE_MAC_SAT_EN
    logic signed [SAT_W-1:0] madd_w, msub_w, mul_w, acc_w;
    always_comb begin
        madd_w   = sat_add(SAT_W'($signed(d.product)), SAT_W'($signed(d.c)), DATA_W);
        msub_w   = sat_add(SAT_W'($signed(d.product)), -SAT_W'($signed(d.c)), DATA_W);
        mul_w    = sat_add(SAT_W'($signed(d.product)), '0, DATA_W);
        acc_w    = sat_add(SAT_W'($signed(d.product)), state == OPEN ? SAT_W'($signed(acc)) : '0, DATA_W);
        op_res   = d.op == OP_MADD ? madd_w[DATA_W-1:0] :
                   d.op == OP_MSUB ? msub_w[DATA_W-1:0] :
                   d.op == OP_MUL  ? mul_w[DATA_W-1:0]  : d.a;
        acc_next = acc_w[DATA_W-1:0];
    end
`else
    always_comb begin
        op_res   = d.op == OP_MADD ? d.product + d.c :
                   d.op == OP_MSUB ? d.product - d.c :
                   d.op == OP_MUL  ? d.product       : d.a;
        acc_next = (state == OPEN ? acc : '0) + d.product;
    end
`endif

    // Beat counter restarts at 1 on the first beat of a burst and sticks at all-ones.
    assign cnt_next = state == OPEN ? (&cnt ? cnt : cnt + CNT_W'(1)) : CNT_W'(1);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            run                  <= 1'b0;
            state                <= IDLE;
            acc                  <= '0;
            cnt                  <= '0;
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tdata  <= '0;
            m_axis_result_tuser  <= '0;
        end else begin
            run <= 1'b1;
            if (advance) begin
                // Accumulate beats only produce an output on tlast.
                m_axis_result_tvalid <= d.valid && (d.op != OP_ACC || d.last);
                if (d.valid && d.op == OP_ACC) begin
                    if (d.last) begin
                        m_axis_result_tdata <= acc_next;
                        m_axis_result_tuser <= cnt_next;
                        state               <= IDLE;
                        acc                 <= '0;
                        cnt                 <= '0;
                    end else begin
                        state <= OPEN;
                        acc   <= acc_next;
                        cnt   <= cnt_next;
                    end
                end else if (d.valid) begin
                    m_axis_result_tdata <= op_res;
                    m_axis_result_tuser <= CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// tb_pe_mac_pipe: directed self-checking bench for pe_mac_pipe with a beat-level reference model.
module tb_pe_mac_pipe;

    localparam int DW      = 8;
    localparam int LAT     = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          aclk = 1'b0, aresetn = 1'b0;
    logic          a_v = 1'b0, b_v = 1'b0, c_v = 1'b0, op_v = 1'b0, a_last = 1'b0;
    logic [DW-1:0] a_d = '0, b_d = '0, c_d = '0;
    logic [7:0]    op_d = '0;
    logic          s_rdy, m_v, m_rdy = 1'b1;
    logic [DW-1:0] m_d;
    logic [CW-1:0] m_u;

    int checks = 0, errors = 0, cyc = 0;
    int exp_d[$], exp_u[$], got_d[$], got_u[$], got_c[$];
    bit m_open = 0, held = 0;
    int m_acc = 0, m_cnt = 0, held_d = 0, held_u = 0;

    pe_mac_pipe #(.DATA_W(DW), .LATENCY(LAT), .CNT_W(CW)) dut (
        .aclk                    (aclk),
        .aresetn                 (aresetn),
        .s_axis_a_tvalid         (a_v),
        .s_axis_a_tdata          (a_d),
        .s_axis_a_tlast          (a_last),
        .s_axis_b_tvalid         (b_v),
        .s_axis_b_tdata          (b_d),
        .s_axis_c_tvalid         (c_v),
        .s_axis_c_tdata          (c_d),
        .s_axis_operation_tvalid (op_v),
        .s_axis_operation_tdata  (op_d),
        .s_axis_tready           (s_rdy),
        .m_axis_result_tvalid    (m_v),
        .m_axis_result_tdata     (m_d),
        .m_axis_result_tuser     (m_u),
        .m_axis_result_tready    (m_rdy)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int fix(input int x);
`ifdef PE_MAC_SAT_EN
        return x > 127 ? 127 : x < -128 ? -128 : x;
`else
        return int'(byte'(x));
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gd(input int i);
        return i < got_d.size() ? got_d[i] : -9999;
    endfunction

    function automatic int gu(input int i);
        return i < got_u.size() ? got_u[i] : -9999;
    endfunction

    // Reference: results follow acceptance order; an accumulate burst yields one result on tlast.
    function automatic void model_beat(input int op, input int a, input int b, input int c, input bit last);
        if (op == 3) begin
            m_acc  = m_open ? fix(m_acc + a * b) : fix(a * b);
            m_cnt  = !m_open ? 1 : (m_cnt == CNT_MAX ? CNT_MAX : m_cnt + 1);
            m_open = !last;
            if (last) begin
                exp_d.push_back(m_acc);
                exp_u.push_back(m_cnt);
            end
        end else begin
            exp_d.push_back(op == 0 ? fix(a * b + c) : op == 1 ? fix(a * b - c) :
                            op == 2 ? fix(a * b) : a);
            exp_u.push_back(1);
        end
    endfunction

    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_d.delete();
            exp_u.delete();
            m_open = 0;
            held   = 0;
        end else begin
            if (held) begin
                chk("hold_valid", int'(m_v), 1);
                chk("hold_data", sx(m_d), held_d);
                chk("hold_user", int'(m_u), held_u);
            end
            held   = m_v && !m_rdy;
            held_d = sx(m_d);
            held_u = int'(m_u);
            if (m_v && m_rdy) begin
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %0d user %0d, expected no output", sx(m_d), m_u);
                end else begin
                    chk("result_data", sx(m_d), exp_d.pop_front());
                    chk("result_user", int'(m_u), exp_u.pop_front());
                end
                got_d.push_back(sx(m_d));
                got_u.push_back(int'(m_u));
                got_c.push_back(cyc);
            end
            if (s_rdy && a_v && b_v && c_v && op_v)
                model_beat(int'(op_d), sx(a_d), sx(b_d), sx(c_d), a_last);
        end
    end

    task automatic present(input int op, input int a, input int b, input int c, input bit last);
        op_d = 8'(op); a_d = DW'(a); b_d = DW'(b); c_d = DW'(c); a_last = last;
        a_v = 1'b1; b_v = 1'b1; c_v = 1'b1; op_v = 1'b1;
    endtask

    task automatic idle();
        a_v = 1'b0; b_v = 1'b0; c_v = 1'b0; op_v = 1'b0; a_last = 1'b0;
    endtask

    task automatic send(input int op, input int a, input int b, input int c, input bit last);
        int n = 0;
        present(op, a, b, c, last);
        @(negedge aclk);
        while (!s_rdy && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tready %0b after 100 cycles, expected 1", s_rdy);
        end
        @(posedge aclk);
        #1;
        idle();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_d.size() != 0 || m_v) && n < 100) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_d.size());
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", int'(m_v), 0);
        chk("rst_tdata", sx(m_d), 0);
        chk("rst_tuser", int'(m_u), 0);
        chk("rst_tready", int'(s_rdy), 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("tready_after_release", int'(s_rdy), 1);

        present(0, 3, 5, 7, 0);
        @(posedge aclk);
        #1;
        idle();
        n = 1;
        while (!m_v && n < 20) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("latency", n, LAT);
        drain();
        chk("madd_data", gd(0), 22);
        chk("madd_user", gu(0), 1);

        send(1, 2, 2, 10, 0);
        send(2, -4, 6, 0, 0);
        drain();
        chk("msub_data", gd(1), -6);
        chk("mul_data", gd(2), -24);
        chk("back_to_back_gap", got_c.size() > 2 ? got_c[2] - got_c[1] : -1, 1);

        send(8'h80, -5, 9, 9, 0);
        send(8'hFF, 77, 1, 1, 1);
        drain();
        chk("pass_80", gd(3), -5);
        chk("pass_ff", gd(4), 77);
        chk("pass_ff_user", gu(4), 1);

        present(0, 1, 1, 1, 0);
        op_v = 1'b0;
        repeat (6) @(posedge aclk);
        #1;
        idle();
        drain();
        chk("partial_valid_count", got_d.size(), 5);

        send(3, 1, 2, 0, 0);
        send(0, 1, 1, 1, 0);
        send(3, 3, 4, 0, 0);
        send(3, 5, 6, 0, 1);
        drain();
        chk("interleaved_madd", gd(5), 2);
        chk("burst_data", gd(6), 44);
        chk("burst_user", gu(6), 3);
        chk("burst_count", got_d.size(), 7);

        m_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) send(2, i, 3, 0, 0);
        fork
            send(2, 5, 3, 0, 0);
            begin
                repeat (5) begin
                    @(negedge aclk);
                    chk("stall_tready", int'(s_rdy), 0);
                    chk("stall_data", sx(m_d), 3);
                end
                @(posedge aclk);
                #1;
                m_rdy = 1'b1;
            end
        join
        drain();
        for (int i = 0; i < 5; i++) chk("stall_order", gd(7 + i), 3 * (i + 1));
        chk("stall_count", got_d.size(), 12);

        for (int i = 1; i <= 18; i++) send(3, 1, 1, 0, i == 18);
        drain();
        chk("long_burst_data", gd(12), 18);
        chk("cnt_saturate", gu(12), CNT_MAX);

        send(0, 100, 2, 0, 0);
        send(3, 100, 1, 0, 0);
        send(3, 100, 1, 0, 0);
        send(3, -100, 1, 0, 1);
        drain();
`ifdef PE_MAC_SAT_EN
        chk("overflow_madd", gd(13), 127);
        chk("overflow_acc", gd(14), 27);
`else
        chk("overflow_madd", gd(13), -56);
        chk("overflow_acc", gd(14), 100);
`endif
        chk("overflow_acc_user", gu(14), 3);

        send(3, 7, 7, 0, 0);
        send(3, 9, 9, 0, 0);
        repeat (6) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("midrst_tvalid", int'(m_v), 0);
        chk("midrst_tdata", sx(m_d), 0);
        chk("midrst_tuser", int'(m_u), 0);
        chk("midrst_tready", int'(s_rdy), 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("midrst_tready_release", int'(s_rdy), 1);
        send(3, 2, 3, 0, 1);
        drain();
        chk("post_reset_data", gd(15), 6);
        chk("post_reset_user", gu(15), 1);
        chk("post_reset_count", got_d.size(), 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_mac_pipe.md
Name: pe_mac_pipe

Overview:
Parametrised successor to the CGRA type-C processing element.
- Signed fixed-point multiply-accumulate PE with a configurable pipeline depth.
- AXI-Stream join on the a/b/c/operation inputs, with real backpressure (tready).
- Adds an accumulate mode that reduces a tlast-delimited burst of a*b products into a single result.
- Sits in a CGRA tile between the routing switch and its output register, and drops into the same slot as the fixed-latency FP MAC PE.

Parameters:
DATA_W, 32, operand/result width, signed two's complement
LATENCY, 4, pipeline stages from input accept to result valid, legal range 2..16
CNT_W, 16, width of the beat counter reported on tuser

Ports:
aclk  in  1  clock
aresetn  in  1  reset
s_axis_a_tvalid  in  1  operand a valid
s_axis_a_tdata  in  DATA_W  operand a
s_axis_a_tlast  in  1  final beat of accumulate burst
s_axis_b_tvalid  in  1  operand b valid
s_axis_b_tdata  in  DATA_W  operand b
s_axis_c_tvalid  in  1  operand c valid
s_axis_c_tdata  in  DATA_W  operand c
s_axis_operation_tvalid  in  1  opcode valid
s_axis_operation_tdata  in  8  opcode
s_axis_tready  out  1  shared ready for all four inputs
m_axis_result_tvalid  out  1  result valid
m_axis_result_tdata  out  DATA_W  result
m_axis_result_tuser  out  CNT_W  beats folded into this result
m_axis_result_tready  in  1  downstream ready

Interface (already decided): one clock; reset is synchronous and active-low (aclk, aresetn).

Behaviour:
- Reset (aresetn low at a rising aclk edge):
  - Clears all stage valids, the accumulator, the open-burst flag and the beat counter.
  - m_axis_result_tvalid=0, m_axis_result_tdata=0, m_axis_result_tuser=0.
  - s_axis_tready=0 during reset; it goes high the first cycle after release.
  - Reset mid-burst discards the partial accumulation; no output is emitted for it.
- Join and accept:
  - A beat is accepted when all four tvalid are high and s_axis_tready is high.
  - A partial set of valids accepts nothing and holds state.
- Stall and ready:
  - advance = !out_valid || m_axis_result_tready.
  - s_axis_tready = advance.
  - The whole pipeline is a shift register that moves only on advance; a global stall holds every stage and the output steady.
- Latency: with no stall, a result is valid exactly LATENCY cycles after the accept edge. Throughput is one beat per cycle.
- Opcodes (latched per beat, travel with the data):
  - 0x00: a*b+c
  - 0x01: a*b-c
  - 0x02: a*b
  - 0x03: accumulate a*b
  - 0x04..0xFF: pass a unchanged
  - All other ops report tuser=1.
- Arithmetic:
  - The full 2*DATA_W product is formed, then truncated to the low DATA_W bits.
  - The add/subtract wraps modulo 2^DATA_W.
- Accumulate FSM (states IDLE and OPEN), evaluated at the final stage:
  - IDLE + op3 beat: acc = a*b, cnt = 1, go to OPEN; if tlast is also set, emit immediately and stay IDLE.
  - OPEN + op3 beat: acc += a*b, cnt++ (cnt saturates at 2^CNT_W-1).
  - op3 beat with tlast: emit acc (including this beat), tuser = cnt, return to IDLE.
  - Non-tlast op3 beats produce no output beat.
  - Non-accumulate beats arriving while OPEN pass through normally and do not disturb acc or cnt.
  - tlast on non-accumulate beats is ignored.
- Output ordering equals input acceptance order, minus the absorbed accumulate beats.

Optional Feature:
Macro PE_MAC_SAT_EN.
- Defined: every op result and every accumulator update saturates to the signed DATA_W range, i.e. [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Saturation is applied per accumulate step, not only at emit.
- Undefined: wrap-around arithmetic as specified above.
- Latency is identical in both builds.

Decomposition:
- Package pe_mac_pkg holds:
  - typedef enum op_e: OP_MADD=0, OP_MSUB=1, OP_MUL=2, OP_ACC=3.
  - stage struct: valid, op, last, a, b, c, product.
  - function sat_add used by the saturating build.
- One sub-module, pe_mac_stage_pipe: a parametrised LATENCY-2 stall-able delay line for the stage struct. The multiply stage and the final accumulate/output stage stay in the top level.

Test Plan:
- LATENCY=4, op0, a=3, b=5, c=7, m_tready held high -> result 22, tvalid 4 cycles after accept, tuser=1.
- Back-to-back op1 a=2, b=2, c=10, then op2 a=-4, b=6 -> outputs -6 then -24 on consecutive cycles.
- op3 burst (1,2), (3,4), (5,6) with tlast on the third beat -> single output 44, tuser=3. One interleaved op0 beat (1,1,1) mid-burst -> 2 emitted between them, accumulation unaffected.
- m_tready low for 5 cycles while the pipeline is full -> s_axis_tready low, output data held stable, no beats lost or duplicated after release.
- Overflow, DATA_W=8, op0 a=100, b=2, c=0:
  - Without PE_MAC_SAT_EN -> -56 (0xC8).
  - With PE_MAC_SAT_EN -> 127.
- aresetn pulsed low for one cycle after two beats of an op3 burst -> no output; a following op3 (2,3) with tlast yields 6, tuser=1.
